// File: rtl/down_counter.sv
// Loadable down counter with an IDLE/RUN control FSM, optional auto-reload and a
// registered single-cycle underflow pulse on terminal count.
module down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             tick,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             underflow
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             underflow_q, underflow_d;

  // Priority: load > stop > start > tick.
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    reload_d    = reload_q;
    underflow_d = 1'b0;
    if (load) begin
      value_d  = load_value;
      reload_d = load_value;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && (value_q != '0)) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (stop) begin
            state_d = StIdle;
          end else if (tick) begin
            if (value_q != '0) begin
              value_d = value_q - WIDTH'(1);
            end else begin
              // Terminal count: never wrap, either reload or end the run.
              underflow_d = 1'b1;
              if (auto_reload) begin
                value_d = reload_q;
              end else begin
                state_d = StIdle;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      value_q     <= '0;
      reload_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      reload_q    <= reload_d;
      underflow_q <= underflow_d;
    end
  end

  assign value     = value_q;
  assign busy      = (state_q == StRun);
  assign underflow = underflow_q;

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the bit width of the counter, reload register and load value.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: load  input  1  when high, captures load_value into the counter and the reload register.
REQ-006 Port: load_value  input  WIDTH  start/reload count.
REQ-007 Port: start  input  1  request to go from IDLE to RUN.
REQ-008 Port: stop  input  1  request to go from RUN to IDLE; the count is held.
REQ-009 Port: tick  input  1  count enable; one decrement per cycle with tick high in RUN.
REQ-010 Port: auto_reload  input  1  when high, underflow reloads the count and stays in RUN; when low, underflow ends the run.
REQ-011 Port: value  output  WIDTH  current count (registered).
REQ-012 Port: busy  output  1  high while in RUN (registered).
REQ-013 Port: underflow  output  1  registered single-cycle pulse on terminal count.

Function
REQ-014 The block SHALL implement two states, IDLE and RUN; busy SHALL equal (state==RUN).
REQ-015 Per-cycle input priority SHALL be load > stop > start > tick.
REQ-016 On load=1, in either state, next value and reload register SHALL both equal load_value.
REQ-017 On load=1, the state SHALL be unchanged, and tick, start and stop SHALL be ignored that cycle.
REQ-018 In RUN with stop=1 and load=0, the next state SHALL be IDLE, value SHALL be held and no decrement SHALL occur.
REQ-019 In IDLE with start=1, load=0 and value!=0, the next state SHALL be RUN; start with value==0 SHALL be ignored (stay IDLE).
REQ-020 start in RUN and stop in IDLE SHALL have no effect.
REQ-021 In IDLE, tick SHALL be ignored and value held.
REQ-022 In RUN with tick=1, no load/stop and value!=0, next value SHALL be value-1.
REQ-023 In RUN with tick=1, no load/stop and value==0, underflow SHALL be 1 in the next cycle.
REQ-024 In that same terminal-count case, if auto_reload=1, next value SHALL be the reload register and the state SHALL remain RUN.
REQ-025 In that same terminal-count case, if auto_reload=0, value SHALL remain 0 and the next state SHALL be IDLE.
REQ-026 underflow SHALL be 0 in every cycle not covered by REQ-023; it SHALL never be high for two consecutive cycles unless two consecutive terminal-count ticks occur (reload register = 0, auto_reload=1).
REQ-027 The count period in auto-reload mode SHALL be reload+1 ticks between underflow pulses.
REQ-028 Arithmetic SHALL be unsigned modulo 2^WIDTH; the counter SHALL never decrement below 0 and no wrap to all-ones SHALL occur.
REQ-029 auto_reload SHALL be sampled only in the terminal-count cycle.
REQ-030 Latency: every input effect SHALL be visible on the outputs one cycle after the sampling edge, with no combinational input-to-output paths.

Reset
REQ-031 While rst=1, value, reload register and underflow SHALL be 0, busy SHALL be 0 and the state SHALL be IDLE, independent of clk.
REQ-032 Reset asserted mid-run SHALL abort the run immediately with no underflow pulse; after release the block SHALL require load and start to run again.

Verification
REQ-033 Scenario (WIDTH=4): load 3, start, tick held high, auto_reload=0 -> value 3,2,1,0 on successive cycles; underflow pulses once on the cycle after the tick at 0; busy falls with the pulse; value stays 0.
REQ-034 Scenario: load 2, auto_reload=1, start, continuous tick -> value 2,1,0,2,1,0,...; underflow pulses every 3 cycles; busy stays 1.
REQ-035 Scenario: load 5, start, tick on alternate cycles, stop asserted when value=3 together with a tick -> value holds 3, busy=0; a later start resumes 3->2 on the next tick.
REQ-036 Scenario: in RUN at value 1, assert load with load_value 9 and tick in the same cycle -> value=9 (no decrement), busy stays 1, no underflow.
REQ-037 Scenario: start with value=0 after reset -> busy stays 0; load 0 then start -> still ignored.
REQ-038 Scenario: load 15, start, tick for 4 cycles, assert rst asynchronously between edges -> value=0, busy=0, underflow=0 immediately; held after release until load/start.
